// File: rtl/limb_serial_adder.sv
// Purpose: wide adder that adds one 4-bit limb per clock, carrying between limbs in a 1-bit register.
// Latency: out_valid rises LIMBS cycles after the accept edge; ops are spaced at least LIMBS+2 cycles apart.
// Backpressure: one op in flight; in_ready is low until the result handshake, and the result is held until out_ready.
module limb_serial_adder #(
  parameter int LIMBS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*LIMBS-1:0] in_a,
  input  logic [4*LIMBS-1:0] in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*LIMBS-1:0] out_sum,
  output logic               out_cout,
  output logic               busy
);

  localparam int W    = 4 * LIMBS;
  localparam int IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(LIMBS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry;
  logic [IDXW-1:0] idx;
  logic [3:0]      a_limb;
  logic [3:0]      b_limb;
  logic [3:0]      limb_sum;
  logic            limb_cout;
  logic            c;
  logic            accept;

  assign accept = in_valid & in_ready;
  assign a_limb = a_reg[4*idx +: 4];
  assign b_limb = b_reg[4*idx +: 4];

  // 4-bit ripple-carry adder for the current limb, fed by the held carry
  always_comb begin
    limb_sum = '0;
    c        = carry;
    for (int i = 0; i < 4; i++) begin
      limb_sum[i] = a_limb[i] ^ b_limb[i] ^ c;
      c           = (a_limb[i] & b_limb[i]) | (c & (a_limb[i] ^ b_limb[i]));
    end
    limb_cout = c;
  end

  // State register; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept in IDLE, step through limbs in RUN, wait for handshake in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready held low during reset
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  // Datapath: capture operands on accept, write one limb of the sum per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            carry   <= in_cin;
            idx     <= '0;
            out_sum <= '0;
          end
        end
        RUN: begin
          out_sum[4*idx +: 4] <= limb_sum;
          carry               <= limb_cout;
          if (idx == LAST) begin
            out_cout <= limb_cout;
            idx      <= '0;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_limb_serial_adder.sv
// Bench for limb_serial_adder: LIMBS=4 and LIMBS=1 instances sharing clock and reset.
// Directed vector table plus hand-written backpressure / reset / random sequences.
// Inputs driven and outputs sampled on the falling edge.
module tb_limb_serial_adder;

  logic        clk;
  logic        rst;

  logic        in_valid4, in_ready4, in_cin4, out_valid4, out_ready4, out_cout4, busy4;
  logic [15:0] a4, b4, out_sum4;

  logic        in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1, busy1;
  logic [3:0]  a1, b1, out_sum1;

  int n_cmp;
  int n_bad;

  limb_serial_adder #(.LIMBS(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(a4), .in_b(b4), .in_cin(in_cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_cout(out_cout4), .busy(busy4)
  );

  limb_serial_adder #(.LIMBS(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(a1), .in_b(b1), .in_cin(in_cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec4_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One complete op on the 4-limb instance; starts and ends on a falling edge
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                     input logic [15:0] es, input logic ec, input string nm);
    int cnt;
    check({nm, ".in_ready"}, in_ready4, 1);
    in_valid4 = 1'b1; a4 = a; b4 = b; in_cin4 = cin;
    @(negedge clk);
    in_valid4 = 1'b0; a4 = ~a; b4 = 16'h5A5A; in_cin4 = ~cin;
    check({nm, ".busy"}, busy4, 1);
    cnt = 0;
    while (!out_valid4 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({nm, ".latency"}, cnt, 4);
    check({nm, ".sum"}, out_sum4, es);
    check({nm, ".cout"}, out_cout4, ec);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check({nm, ".valid_drop"}, out_valid4, 0);
    check({nm, ".ready_back"}, in_ready4, 1);
  endtask

  // One complete op on the 1-limb instance
  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                     input logic [3:0] es, input logic ec, input string nm);
    int cnt;
    check({nm, ".in_ready"}, in_ready1, 1);
    in_valid1 = 1'b1; a1 = a; b1 = b; in_cin1 = cin;
    @(negedge clk);
    in_valid1 = 1'b0; a1 = ~a; b1 = 4'h5; in_cin1 = ~cin;
    cnt = 0;
    while (!out_valid1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({nm, ".latency"}, cnt, 1);
    check({nm, ".sum"}, out_sum1, es);
    check({nm, ".cout"}, out_cout1, ec);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check({nm, ".valid_drop"}, out_valid1, 0);
  endtask

  initial begin
    vec4_t       tbl[6];
    int          cnt;
    logic [3:0]  ra, rb;
    logic        rc;
    logic [4:0]  rexp;

    tbl[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sum: 16'h5555, cout: 1'b0};
    tbl[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, sum: 16'h0000, cout: 1'b1};
    tbl[2] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1};
    tbl[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
    tbl[4] = '{a: 16'h00FF, b: 16'h0001, cin: 1'b0, sum: 16'h0100, cout: 1'b0};
    tbl[5] = '{a: 16'hABCD, b: 16'h1111, cin: 1'b1, sum: 16'hBCDF, cout: 1'b0};

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; in_cin4 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; in_cin1 = 1'b0;

    // Reset state, sampled while reset is still asserted
    repeat (3) @(negedge clk);
    check("rst.in_ready", in_ready4, 0);
    check("rst.out_valid", out_valid4, 0);
    check("rst.busy", busy4, 0);
    check("rst.out_sum", out_sum4, 0);
    check("rst.out_cout", out_cout4, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.in_ready", in_ready4, 1);

    // out_ready while idle must be ignored
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check("idle_ordy.in_ready", in_ready4, 1);
    check("idle_ordy.busy", busy4, 0);

    for (int i = 0; i < 6; i++)
      op4(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, $sformatf("vec%0d", i));

    // Backpressure: result held for 5 cycles while a new op is offered
    in_valid4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222; in_cin4 = 1'b0;
    @(negedge clk);
    a4 = 16'h0001; b4 = 16'h0001;
    cnt = 0;
    while (!out_valid4 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("bp.latency", cnt, 4);
    for (int i = 0; i < 5; i++) begin
      check("bp.out_valid", out_valid4, 1);
      check("bp.out_sum", out_sum4, 16'h3333);
      check("bp.in_ready", in_ready4, 0);
      @(negedge clk);
    end
    // Release the result with out_ready held high; queued in_valid is accepted after IDLE
    out_ready4 = 1'b1;
    @(negedge clk);
    check("bp.hs_valid", out_valid4, 0);
    check("bp.hs_in_ready", in_ready4, 1);
    @(negedge clk);
    in_valid4 = 1'b0;
    check("bp.new_busy", busy4, 1);
    cnt = 0;
    while (!out_valid4 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("bp.new_latency", cnt, 4);
    check("bp.new_sum", out_sum4, 16'h0002);
    @(negedge clk);
    check("bp.done_one_cycle", out_valid4, 0);
    out_ready4 = 1'b0;

    // Reset after two RUN cycles aborts the op
    in_valid4 = 1'b1; a4 = 16'h0FFF; b4 = 16'h0001; in_cin4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b0;
    repeat (2) @(negedge clk);
    check("abort.mid_busy", busy4, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort.out_valid", out_valid4, 0);
    check("abort.out_sum", out_sum4, 0);
    check("abort.busy", busy4, 0);
    check("abort.in_ready", in_ready4, 0);
    rst = 1'b0;
    @(negedge clk);
    op4(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, "post_abort");

    // Single-limb instance
    op1(4'h9, 4'h8, 1'b1, 4'h2, 1'b1, "l1_dir");
    for (int i = 0; i < 1000; i++) begin
      ra   = 4'($urandom_range(0, 15));
      rb   = 4'($urandom_range(0, 15));
      rc   = 1'($urandom_range(0, 1));
      rexp = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
      op1(ra, rb, rc, rexp[3:0], rexp[4], "l1_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
